// File: rtl/hamming_rx_ctrl.sv
// hamming_rx_ctrl: receive-side sequencer for Hamming(7,4) codewords.
// Latency: out_valid rises after the second clock edge following acceptance; one word per 4 cycles.
// Backpressure: result is held stable while out_ready=0; in_ready is high only in IDLE.
//
// Ports: clk/rst (async active-high); in_valid/in_ready/in_word (7-bit codeword
// [i3,i2,i1,c2,i0,c1,c0]); out_valid/out_ready with data_out {i3,i2,i1,i0},
// err_flag, err_pos (1..7, 0 = clean); cnt_clr / err_count corrected-word counter.
// Optional feature: define HAMMING_STATS_EN to build the saturating err_count;
// otherwise err_count is tied to 0 and cnt_clr is ignored.

// module_corrector_error: flips one bit of a 7-bit word.
// The bit index is the bit-reverse of sindrome; index 7 (sindrome 3'b111) flips nothing.
module module_corrector_error (
  input  logic [6:0] word,
  input  logic [2:0] sindrome,
  output logic [6:0] corrected
);
  logic [2:0] idx;

  assign idx = {sindrome[0], sindrome[1], sindrome[2]};

  always_comb begin
    corrected = word;
    if (idx != 3'd7) corrected[idx] = ~word[idx];
  end
endmodule

module hamming_rx_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             err_flag,
  output logic [2:0]       err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYND = 2'd1;
  localparam logic [1:0] CORR = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0] state;
  logic [6:0] word_q;
  logic [2:0] pos_q;
  logic [2:0] pos_m1;
  logic [2:0] sind;
  logic [6:0] corr;

  // Both handshake outputs decode the state register only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // Hamming position p maps to word bit p-1; the corrector expects that index
  // bit-reversed. pos=0 wraps to 7, which the corrector treats as "no flip".
  assign pos_m1 = pos_q - 3'd1;
  assign sind   = {pos_m1[0], pos_m1[1], pos_m1[2]};

  module_corrector_error u_corr (
    .word      (word_q),
    .sindrome  (sind),
    .corrected (corr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_q   <= '0;
      pos_q    <= '0;
      data_out <= '0;
      err_flag <= 1'b0;
      err_pos  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q <= in_word;
            state  <= SYND;
          end
        end
        SYND: begin
          pos_q[0] <= word_q[0] ^ word_q[2] ^ word_q[4] ^ word_q[6];
          pos_q[1] <= word_q[1] ^ word_q[2] ^ word_q[5] ^ word_q[6];
          pos_q[2] <= word_q[3] ^ word_q[4] ^ word_q[5] ^ word_q[6];
          state    <= CORR;
        end
        CORR: begin
          data_out <= {corr[6], corr[5], corr[4], corr[2]};
          err_pos  <= pos_q;
          err_flag <= (pos_q != 3'd0);
          state    <= HOLD;
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

  // Check bits of the corrected word are not part of the result.
  logic unused_corr;
  assign unused_corr = ^{corr[3], corr[1], corr[0]};

`ifdef HAMMING_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (state == CORR && pos_q != 3'd0 && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign err_count  = '0;
`endif
endmodule

// File: tb/tb_hamming_rx_ctrl.sv
module tb_hamming_rx_ctrl;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_word;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       data_out;
  logic             err_flag;
  logic [2:0]       err_pos;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_count;

  hamming_rx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err_flag  (err_flag),
    .err_pos   (err_pos),
    .cnt_clr   (cnt_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       flag;
    logic [2:0] pos;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Encode nibble {i3,i2,i1,i0} into [i3,i2,i1,c2,i0,c1,c0].
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic c0, c1, c2;
    c0 = d[0] ^ d[1] ^ d[3];
    c1 = d[0] ^ d[2] ^ d[3];
    c2 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], c2, d[0], c1, c0};
  endfunction

  function automatic logic [3:0] extract(input logic [6:0] w);
    return {w[6], w[5], w[4], w[2]};
  endfunction

  // Nearest-codeword search: the perfect code gives exactly one candidate.
  function automatic exp_t model(input logic [6:0] w);
    exp_t e;
    logic [6:0] t;
    e.data = extract(w);
    e.flag = 1'b0;
    e.pos  = 3'd0;
    if (encode(extract(w)) != w) begin
      for (int k = 0; k < 7; k++) begin
        t = w ^ (7'd1 << k);
        if (encode(extract(t)) == t) begin
          e.data = extract(t);
          e.flag = 1'b1;
          e.pos  = 3'(k + 1);
        end
      end
    end
    return e;
  endfunction

  // One full transaction, entered and left at a negedge.
  task automatic xfer(input logic [6:0] w, input int stall, input logic clr);
    exp_t e;
    exp_t got;
    int   n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_word  = w;
    in_valid = 1'b1;
    cnt_clr  = clr;
    e = model(w);
    sb.push_back(e);
`ifdef HAMMING_STATS_EN
    if (clr) exp_cnt = 0;
    else if (e.pos != 3'd0 && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
    @(negedge clk);              // acceptance edge E passed
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    @(negedge clk);              // E+1
    chk("lat_e1_out_valid", out_valid, 0);
    @(negedge clk);              // E+2
    chk("lat_e2_out_valid", out_valid, 1);
    // Stall with a competing word offered; it must be ignored.
    in_word  = ~w;
    in_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", data_out, e.data);
      chk("stall_pos", err_pos, e.pos);
    end
    in_valid = 1'b0;
    got = sb.pop_front();
    chk("data_out", data_out, got.data);
    chk("err_flag", err_flag, got.flag);
    chk("err_pos", err_pos, got.pos);
    chk("err_count", err_count, exp_cnt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    chk("done_out_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_data_kept", data_out, got.data);
  endtask

  logic [3:0] d;
  logic [6:0] w;
  int         k;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_flag", err_flag, 0);
    chk("rst_pos", err_pos, 0);
    chk("rst_count", err_count, 0);
    rst = 1'b0;
    @(negedge clk);

    xfer(7'h55, 0, 1'b0);
    chk("h55_data", data_out, 4'b1011);
    xfer(7'h51, 0, 1'b0);
    chk("h51_pos", err_pos, 3);
    xfer(7'h5D, 5, 1'b0);
    chk("h5d_pos", err_pos, 4);
    // Push the counter into saturation.
    xfer(7'h54, 1, 1'b0);
    xfer(7'h15, 0, 1'b0);
    xfer(7'h57, 2, 1'b0);
    // Clear together with an erroneous word.
    xfer(7'h51, 0, 1'b1);
    chk("clr_count", err_count, 0);
    // Double-bit error is miscorrected as a single error.
    xfer(7'h55 ^ 7'h03, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d = 4'($urandom);
      w = encode(d);
      k = $urandom_range(0, 7);
      if (k < 7) w = w ^ (7'd1 << k);
      xfer(w, $urandom_range(0, 3), 1'b0);
    end

    // Reset during SYND aborts the word.
    in_word  = 7'h51;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_data", data_out, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_output", out_valid, 0);
    end
    chk("abort_count", err_count, 0);
    xfer(7'h5D, 0, 1'b0);
    chk("post_abort_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
